la_capture_ctrl: RTL

Capture sequencer for the logic-analyser sample RAM. It sits between the sample source (PMOD divider/channel path or the UART sniffer) and the RAM write port. It arms a capture, fills a pre-trigger history in ring-buffer fashion, and detects a configurable trigger. It then records a fixed post-trigger count and reports the oldest-sample address, so readback can linearise the ring.

---
 rtl/la_pkg.sv | 18 +
 rtl/la_trig_match.sv | 31 +++
 rtl/la_capture_ctrl.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/la_pkg.sv
// Shared definitions for the logic-analyser blocks.
// Sequencer state encoding and trigger mode codes.
package la_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PRE,
        ST_WAIT,
        ST_POST,
        ST_DONE
    } la_state_t;

    localparam logic [1:0] TRIG_IMM   = 2'd0;
    localparam logic [1:0] TRIG_LEVEL = 2'd1;
    localparam logic [1:0] TRIG_RISE  = 2'd2;
    localparam logic [1:0] TRIG_FALL  = 2'd3;

endpackage

// File: rtl/la_trig_match.sv
// Combinational trigger matcher for the capture sequencer.
// Edge modes need a valid previous sample to fire.
module la_trig_match
    import la_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic [DATA_W-1:0] i_sample,
    input  logic [DATA_W-1:0] i_prev,
    input  logic              i_prev_valid,
    input  logic [1:0]        i_mode,
    input  logic [DATA_W-1:0] i_mask,
    input  logic [DATA_W-1:0] i_value,
    output logic              o_hit
);

    always_comb begin
        o_hit = 1'b0;
        unique case (1'b1)
            (i_mode == TRIG_IMM):
                o_hit = 1'b1;
            (i_mode == TRIG_LEVEL):
                o_hit = ((i_sample ^ i_value) & i_mask) == '0;
            (i_mode == TRIG_RISE):
                o_hit = i_prev_valid && (|(i_sample & ~i_prev & i_mask));
            default:
                o_hit = i_prev_valid && (|(~i_sample & i_prev & i_mask));
        endcase
    end

endmodule

// File: rtl/la_capture_ctrl.sv
// Capture sequencer: ring-buffer pre-trigger fill, trigger detect,
// fixed post-trigger count and oldest-sample address report.
module la_capture_ctrl
    import la_pkg::*;
#(
    parameter int ADDR_W = 17,
    parameter int DATA_W = 8
) (
    input  logic              clk_50M,
    input  logic              rst_n,
    input  logic              arm,
    input  logic              abort,
    input  logic              sample_valid,
    input  logic [DATA_W-1:0] sample_data,
    input  logic [1:0]        trig_mode,
    input  logic [DATA_W-1:0] trig_mask,
    input  logic [DATA_W-1:0] trig_value,
    input  logic [ADDR_W-1:0] pre_len,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data,
    output logic              busy,
    output logic              triggered,
    output logic              done,
    output logic [ADDR_W-1:0] start_addr
);

    la_state_t         r_state;
    la_state_t         w_next;
    logic [1:0]        r_mode;
    logic [DATA_W-1:0] r_mask;
    logic [DATA_W-1:0] r_value;
    logic [ADDR_W-1:0] r_pre_len;
    logic [ADDR_W-1:0] r_wr_ptr;
    logic [ADDR_W-1:0] r_pre_cnt;
    logic [ADDR_W-1:0] r_post_cnt;
    logic [DATA_W-1:0] r_prev;
    logic              r_prev_valid;
    logic              r_wr_en;
    logic [ADDR_W-1:0] r_wr_addr;
    logic [DATA_W-1:0] r_wr_data;
    logic              r_triggered;
    logic              r_done;
    logic [ADDR_W-1:0] r_start_addr;

    logic              w_busy;
    logic              w_arm_ok;
    logic              w_accept;
    logic              w_hit;
    logic [ADDR_W-1:0] w_pre_inc;
    logic [ADDR_W-1:0] w_post_init;

    // A pre_len port of ADDR_W bits can never exceed DEPTH-1.
    assign w_busy      = (r_state == ST_PRE) || (r_state == ST_WAIT)
                      || (r_state == ST_POST);
    assign w_arm_ok    = arm && !abort
                      && ((r_state == ST_IDLE) || (r_state == ST_DONE));
    assign w_accept    = sample_valid && w_busy && !abort;
    assign w_pre_inc   = r_pre_cnt + 1'b1;
    assign w_post_init = ~r_pre_len;

    la_trig_match #(
        .DATA_W (DATA_W)
    ) u_match (
        .i_sample     (sample_data),
        .i_prev       (r_prev),
        .i_prev_valid (r_prev_valid),
        .i_mode       (r_mode),
        .i_mask       (r_mask),
        .i_value      (r_value),
        .o_hit        (w_hit)
    );

    always_ff @(posedge clk_50M) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        if (abort) begin
            w_next = ST_IDLE;
        end else begin
            unique case (r_state)
                ST_IDLE, ST_DONE: begin
                    if (arm)
                        w_next = (pre_len == '0) ? ST_WAIT : ST_PRE;
                end
                ST_PRE: begin
                    if (w_accept && (w_pre_inc == r_pre_len))
                        w_next = ST_WAIT;
                end
                ST_WAIT: begin
                    if (w_accept && w_hit)
                        w_next = (w_post_init == '0) ? ST_DONE : ST_POST;
                end
                ST_POST: begin
                    if (w_accept && (r_post_cnt == ADDR_W'(1)))
                        w_next = ST_DONE;
                end
                default: w_next = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_50M) begin
        if (!rst_n) begin
            r_mode       <= '0;
            r_mask       <= '0;
            r_value      <= '0;
            r_pre_len    <= '0;
            r_wr_ptr     <= '0;
            r_pre_cnt    <= '0;
            r_post_cnt   <= '0;
            r_prev       <= '0;
            r_prev_valid <= 1'b0;
            r_wr_en      <= 1'b0;
            r_wr_addr    <= '0;
            r_wr_data    <= '0;
            r_triggered  <= 1'b0;
            r_done       <= 1'b0;
            r_start_addr <= '0;
        end else begin
            r_wr_en <= 1'b0;
            if (abort) begin
                r_triggered <= 1'b0;
                r_done      <= 1'b0;
            end else if (w_arm_ok) begin
                r_mode       <= trig_mode;
                r_mask       <= trig_mask;
                r_value      <= trig_value;
                r_pre_len    <= pre_len;
                r_wr_ptr     <= '0;
                r_pre_cnt    <= '0;
                r_post_cnt   <= '0;
                r_prev_valid <= 1'b0;
                r_triggered  <= 1'b0;
                r_done       <= 1'b0;
                r_start_addr <= '0;
            end else if (w_accept) begin
                r_wr_en      <= 1'b1;
                r_wr_addr    <= r_wr_ptr;
                r_wr_data    <= sample_data;
                r_wr_ptr     <= r_wr_ptr + 1'b1;
                r_prev       <= sample_data;
                r_prev_valid <= 1'b1;
                if (r_state == ST_PRE)
                    r_pre_cnt <= w_pre_inc;
                // Oldest sample sits pre_len slots behind the trigger.
                if ((r_state == ST_WAIT) && w_hit) begin
                    r_triggered  <= 1'b1;
                    r_start_addr <= r_wr_ptr - r_pre_len;
                    r_post_cnt   <= w_post_init;
                    if (w_post_init == '0)
                        r_done <= 1'b1;
                end
                if (r_state == ST_POST) begin
                    r_post_cnt <= r_post_cnt - 1'b1;
                    if (r_post_cnt == ADDR_W'(1))
                        r_done <= 1'b1;
                end
            end
        end
    end

    assign wr_en      = r_wr_en;
    assign wr_addr    = r_wr_addr;
    assign wr_data    = r_wr_data;
    assign busy       = w_busy;
    assign triggered  = r_triggered;
    assign done       = r_done;
    assign start_addr = r_start_addr;

endmodule
